// File: rtl/actuator_driver_pkg.sv
// Shared washer constants: controller state codes, motor speed codes and the
// agitation sequencer state encoding. Imported by the actuator driver and by
// the washer controller so both sides agree on every encoding.
package actuator_driver_pkg;

  localparam int CNT_W = 32;

  // Controller state codes; 101..111 are invalid and flag a fault.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FILLING  = 3'b001,
    ST_WASHING  = 3'b010,
    ST_RINSING  = 3'b011,
    ST_SPINNING = 3'b100
  } washer_state_e;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'b00,
    SPD_AGIT = 2'b01,
    SPD_LOW  = 2'b10,
    SPD_HIGH = 2'b11
  } motor_speed_e;

  typedef enum logic [1:0] {
    AG_FWD  = 2'b00,
    AG_GAP1 = 2'b01,
    AG_REV  = 2'b10,
    AG_GAP2 = 2'b11
  } agit_state_e;

endpackage

// File: rtl/actuator_driver_agitation_sequencer.sv
// Agitation sequencer: forward / gap / reverse / gap drum pattern.
// Ports:
//   clk_top, reset  - clock, synchronous active-low reset
//   restart         - drum-phase entry this cycle; sequence starts over at AG_FWD
//   run             - washing or rinsing is sampled this cycle
//   motor_en/dir    - drive for the cycle being entered (parent registers them)
// Outputs are Mealy on restart so the first cycle after entry is already
// forward without an extra cycle of latency in the parent.
module agitation_sequencer
  import actuator_driver_pkg::*;
#(
  parameter logic [CNT_W-1:0] AGIT_ON  = 32'd50000000,
  parameter logic [CNT_W-1:0] AGIT_GAP = 32'd10000000
) (
  input  logic clk_top,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic motor_en,
  output logic motor_dir
);

  agit_state_e ag_q, ag_d, ag_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff, len;

  always_ff @(posedge clk_top) begin
    if (!reset) begin
      ag_q  <= AG_FWD;
      cnt_q <= '0;
    end else begin
      ag_q  <= ag_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    ag_eff    = restart ? AG_FWD : ag_q;
    cnt_eff   = restart ? '0 : cnt_q;
    motor_en  = run && (ag_eff == AG_FWD || ag_eff == AG_REV);
    motor_dir = run && (ag_eff == AG_REV);
    len       = (ag_eff == AG_FWD || ag_eff == AG_REV) ? AGIT_ON : AGIT_GAP;
    ag_d      = ag_eff;
    cnt_d     = cnt_eff + 32'd1;
    if (!run) begin
      ag_d  = AG_FWD;
      cnt_d = '0;
    end else if (cnt_eff + 32'd1 >= len) begin
      // Terminal count: counter resets, phase advances (gaps skipped when zero).
      cnt_d = '0;
      unique case (ag_eff)
        AG_FWD:  ag_d = (AGIT_GAP == '0) ? AG_REV : AG_GAP1;
        AG_GAP1: ag_d = AG_REV;
        AG_REV:  ag_d = (AGIT_GAP == '0) ? AG_FWD : AG_GAP2;
        default: ag_d = AG_FWD;
      endcase
    end
  end

endmodule

// File: rtl/actuator_driver.sv
// Washer actuator driver: maps the controller state onto valve, pump, drum
// motor, door latch and buzzer. Every output is a flop reflecting the inputs
// sampled on the previous clk_top edge.
// Ports:
//   clk_top, reset        - clock, synchronous active-low reset
//   current_state[2:0]    - controller state code
//   wash_done, pause      - completion flag, spin hold request
//   water_valve, drain_pump, motor_en, motor_dir, motor_speed[1:0],
//   door_lock, buzzer, fault - actuator drives and invalid-state flag
module actuator_driver
  import actuator_driver_pkg::*;
#(
  parameter logic [CNT_W-1:0] AGIT_ON       = 32'd50000000,
  parameter logic [CNT_W-1:0] AGIT_GAP      = 32'd10000000,
  parameter logic [CNT_W-1:0] RAMP_STEP     = 32'd20000000,
  parameter logic [CNT_W-1:0] UNLOCK_DELAY  = 32'd30000000,
  parameter logic [CNT_W-1:0] BUZZER_CYCLES = 32'd5000000
) (
  input  logic       clk_top,
  input  logic       reset,
  input  logic [2:0] current_state,
  input  logic       wash_done,
  input  logic       pause,
  output logic       water_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic [1:0] motor_speed,
  output logic       door_lock,
  output logic       buzzer,
  output logic       fault
);

  logic [2:0]       prev_state;
  logic             wd_q;
  logic [CNT_W-1:0] ramp_cnt, unlock_cnt, buzz_cnt;
  logic             restart, agit_run, agit_en, agit_dir, spin_hi, wd_rise;

  assign restart  = (current_state != prev_state);
  assign agit_run = (current_state == ST_WASHING) || (current_state == ST_RINSING);
  // ramp_cnt is held at 0 outside SPINNING, so no entry detect is needed here.
  assign spin_hi  = (ramp_cnt >= RAMP_STEP);
  assign wd_rise  = wash_done && !wd_q;

  agitation_sequencer #(
    .AGIT_ON  (AGIT_ON),
    .AGIT_GAP (AGIT_GAP)
  ) u_agit (
    .clk_top   (clk_top),
    .reset     (reset),
    .restart   (restart),
    .run       (agit_run),
    .motor_en  (agit_en),
    .motor_dir (agit_dir)
  );

  always_ff @(posedge clk_top) begin
    if (!reset) begin
      prev_state  <= ST_IDLE;
      wd_q        <= 1'b0;
      ramp_cnt    <= '0;
      unlock_cnt  <= '0;
      buzz_cnt    <= '0;
      water_valve <= 1'b0;
      drain_pump  <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      motor_speed <= SPD_OFF;
      door_lock   <= 1'b0;
      buzzer      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      prev_state  <= current_state;
      wd_q        <= wash_done;

      water_valve <= 1'b0;
      drain_pump  <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      motor_speed <= SPD_OFF;
      fault       <= 1'b0;
      ramp_cnt    <= '0;

      case (current_state)
        ST_IDLE: ;
        ST_FILLING: water_valve <= 1'b1;
        ST_WASHING, ST_RINSING: begin
          drain_pump  <= (current_state == ST_RINSING);
          motor_en    <= agit_en;
          motor_dir   <= agit_dir;
          motor_speed <= agit_en ? SPD_AGIT : SPD_OFF;
        end
        ST_SPINNING: begin
          drain_pump <= 1'b1;
          if (!pause) begin
            motor_en    <= 1'b1;
            motor_speed <= spin_hi ? SPD_HIGH : SPD_LOW;
            ramp_cnt    <= spin_hi ? ramp_cnt : ramp_cnt + 32'd1;
          end
        end
        default: fault <= 1'b1;
      endcase

      // Lock holds through any non-idle code; in IDLE it counts down only if it
      // was engaged, so coming out of reset the door stays free.
      if (current_state != ST_IDLE) begin
        door_lock  <= 1'b1;
        unlock_cnt <= '0;
      end else if (door_lock && unlock_cnt < UNLOCK_DELAY) begin
        unlock_cnt <= unlock_cnt + 32'd1;
      end else begin
        door_lock  <= 1'b0;
        unlock_cnt <= '0;
      end

      // Rising edge (re)starts the pulse; buzz_cnt counts cycles already high.
      if (wd_rise) begin
        buzzer   <= 1'b1;
        buzz_cnt <= 32'd1;
      end else if (buzzer && buzz_cnt < BUZZER_CYCLES) begin
        buzz_cnt <= buzz_cnt + 32'd1;
      end else begin
        buzzer   <= 1'b0;
        buzz_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_actuator_driver.sv
// Scoreboard bench: the stimulus process pushes the expected output vector for
// each cycle it drives; a monitor pops and compares just after each clock edge.
// Vector layout: {water_valve, drain_pump, motor_en, motor_dir, motor_speed,
//                 door_lock, buzzer, fault}.
module tb_actuator_driver;

  logic       clk_top = 1'b0;
  logic       reset, wash_done, pause;
  logic [2:0] current_state;
  logic       water_valve, drain_pump, motor_en, motor_dir, door_lock, buzzer, fault;
  logic [1:0] motor_speed;

  typedef struct {
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [2:0] S_IDLE = 3'b000, S_FILL = 3'b001, S_WASH = 3'b010,
                         S_RINSE = 3'b011, S_SPIN = 3'b100;

  actuator_driver #(
    .AGIT_ON(32'd4), .AGIT_GAP(32'd2), .RAMP_STEP(32'd3),
    .UNLOCK_DELAY(32'd5), .BUZZER_CYCLES(32'd3)
  ) dut (
    .clk_top(clk_top), .reset(reset), .current_state(current_state),
    .wash_done(wash_done), .pause(pause), .water_valve(water_valve),
    .drain_pump(drain_pump), .motor_en(motor_en), .motor_dir(motor_dir),
    .motor_speed(motor_speed), .door_lock(door_lock), .buzzer(buzzer),
    .fault(fault)
  );

  always #5 clk_top = ~clk_top;

  function automatic logic [8:0] ev(input logic wv, input logic dp, input logic en,
                                    input logic dir, input logic [1:0] spd,
                                    input logic dl, input logic bz, input logic flt);
    return {wv, dp, en, dir, spd, dl, bz, flt};
  endfunction

  // Drive one cycle of inputs (at a negedge) and queue what the next edge must produce.
  task automatic cyc(input logic [2:0] st, input logic rst_n, input logic wd,
                     input logic p, input logic [8:0] e, input string nm);
    exp_t x;
    current_state = st;
    reset         = rst_n;
    wash_done     = wd;
    pause         = p;
    x.v  = e;
    x.nm = nm;
    q.push_back(x);
    @(negedge clk_top);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk_top);
      #1;
      if (q.size() > 0) begin
        m_e = q.pop_front();
        n_cmp++;
        if ({water_valve, drain_pump, motor_en, motor_dir, motor_speed,
             door_lock, buzzer, fault} !== m_e.v) begin
          n_err++;
          $display("FAIL %s: got %b expected %b (t=%0t)", m_e.nm,
                   {water_valve, drain_pump, motor_en, motor_dir, motor_speed,
                    door_lock, buzzer, fault}, m_e.v, $time);
        end
      end
    end
  end

  // Stimulus
  logic [1:0] spd_tab [8];
  initial begin
    int ph;
    logic en, dir, p;
    spd_tab = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10};
    current_state = S_IDLE; reset = 1'b0; wash_done = 1'b0; pause = 1'b0;
    @(negedge clk_top);

    repeat (2) cyc(S_IDLE, 0, 0, 0, ev(0,0,0,0,2'b00,0,0,0), "reset_state");
    repeat (2) cyc(S_IDLE, 1, 0, 0, ev(0,0,0,0,2'b00,0,0,0), "idle_after_reset");
    repeat (3) cyc(S_FILL, 1, 0, 0, ev(1,0,0,0,2'b00,1,0,0), "filling");

    // 4 fwd, 2 off, 4 rev, 2 off, 2 fwd
    for (int i = 0; i < 14; i++) begin
      ph  = i % 12;
      en  = (ph < 4) || (ph >= 6 && ph < 10);
      dir = (ph >= 6 && ph < 10);
      cyc(S_WASH, 1, 0, 0, ev(0,0,en,dir,en ? 2'b01 : 2'b00,1,0,0), "wash_agitation");
    end

    // Rinse restarts at forward; pause must be ignored here.
    repeat (3) cyc(S_RINSE, 1, 0, 1, ev(0,1,1,0,2'b01,1,0,0), "rinse_restart");

    // Double wash: rinse left 3 fwd cycles used, wash must give a full 4 again.
    for (int i = 0; i < 6; i++) begin
      en = (i < 4);
      cyc(S_WASH, 1, 0, 0, ev(0,0,en,0,en ? 2'b01 : 2'b00,1,0,0), "double_wash_restart");
    end

    for (int i = 0; i < 8; i++) begin
      p = (i == 5 || i == 6);
      cyc(S_SPIN, 1, 0, p, ev(0,1,!p,0,spd_tab[i],1,0,0), "spin_ramp_pause");
    end

    for (int i = 0; i < 7; i++)
      cyc(S_IDLE, 1, i == 0, 0, ev(0,0,0,0,2'b00,i < 5,i < 3,0), "idle_unlock_buzzer");

    for (int i = 0; i < 7; i++)
      cyc(S_IDLE, 1, (i == 0 || i == 2), 0, ev(0,0,0,0,2'b00,0,i < 5,0), "buzzer_retrigger");

    repeat (2) cyc(3'b111, 1, 0, 0, ev(0,0,0,0,2'b00,1,0,1), "fault_111");
    cyc(3'b101, 1, 0, 1, ev(0,0,0,0,2'b00,1,0,1), "fault_101");
    repeat (2) cyc(S_IDLE, 1, 0, 0, ev(0,0,0,0,2'b00,1,0,0), "fault_clear_idle");
    cyc(S_FILL, 1, 0, 0, ev(1,0,0,0,2'b00,1,0,0), "refill_before_unlock");
    for (int i = 0; i < 7; i++)
      cyc(S_IDLE, 1, 0, 0, ev(0,0,0,0,2'b00,i < 5,0,0), "unlock_counter_cleared");

    repeat (3) cyc(S_WASH, 1, 0, 0, ev(0,0,1,0,2'b01,1,0,0), "wash_before_reset");
    cyc(S_WASH, 0, 0, 0, ev(0,0,0,0,2'b00,0,0,0), "reset_mid_wash");
    repeat (2) cyc(S_IDLE, 1, 0, 0, ev(0,0,0,0,2'b00,0,0,0), "idle_after_mid_reset");

    repeat (2) @(negedge clk_top);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
